tt_sel_seq: RTL and testbench

//  Selection sequencer for the mux controller: drives ctrl_sel_rst_n, ctrl_sel_inc and ctrl_ena.

---
 rtl/tt_sel_seq_if.sv | 24 ++
 rtl/tt_sel_seq.sv | 172 +++++++++++++++++
 tb/tb_tt_sel_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_sel_seq_if.sv
// Request/status/control bundle between the config logic, the selection sequencer and the mux controller.
interface tt_sel_seq_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              req_off;
  logic              busy;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;

  modport master (
    output req_valid, req_addr, req_off,
    input  req_ready, busy, cur_addr, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

  modport slave (
    input  req_valid, req_addr, req_off,
    output req_ready, busy, cur_addr, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );
endinterface

// File: rtl/tt_sel_seq.sv
// Selection sequencer: turns an accepted project address into reset / inc-pulse / settle / enable timing.
// Optional macro TT_SEL_SEQ_SHORTCUT_EN: upward re-selection from ACTIVE skips the counter reset.
module tt_sel_seq #(
  parameter int ADDR_W     = 10,
  parameter int RST_CYC    = 2,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sel_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENA_OFF = 3'd1;
  localparam logic [2:0] S_RESET   = 3'd2;
  localparam logic [2:0] S_INC_LO  = 3'd3;
  localparam logic [2:0] S_INC_HI  = 3'd4;
  localparam logic [2:0] S_SETTLE  = 3'd5;
  localparam logic [2:0] S_ACTIVE  = 3'd6;

  localparam int CNT_MAX_A = (RST_CYC > PULSE_CYC) ? RST_CYC : PULSE_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYC) ? CNT_MAX_A : SETTLE_CYC;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              sel_rst_n_q, sel_rst_n_d;
  logic              inc_q, inc_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              can_accept;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
  logic              short_q, short_d;
`endif

  assign can_accept    = ((state_q == S_IDLE) || (state_q == S_ACTIVE)) && !bus.req_off;
  assign bus.req_ready = rst_n && can_accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    target_d   = target_q;
    cur_addr_d = cur_addr_q;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
    short_d    = short_q;
`endif
    case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (bus.req_off) begin
          state_d = S_IDLE;
        end else if (bus.req_valid) begin
          state_d  = S_ENA_OFF;
          cnt_d    = '0;
          rem_d    = bus.req_addr;
          target_d = bus.req_addr;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
          // Moving upward from a live selection only needs the difference in pulses.
          short_d = (state_q == S_ACTIVE) && (bus.req_addr >= cur_addr_q);
          if (short_d) rem_d = bus.req_addr - cur_addr_q;
`endif
        end
      end
      default: begin
        if (bus.req_off) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          case (state_q)
            S_ENA_OFF: begin
              cnt_d   = '0;
              state_d = S_RESET;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
              if (short_q) state_d = (rem_q != '0) ? S_INC_LO : S_SETTLE;
`endif
            end
            S_RESET: begin
              if (cnt_q == RST_LAST) begin
                cnt_d   = '0;
                state_d = (rem_q != '0) ? S_INC_LO : S_SETTLE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_INC_LO: begin
              if (cnt_q == PULSE_LAST) begin
                cnt_d   = '0;
                state_d = S_INC_HI;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_INC_HI: begin
              if (cnt_q == PULSE_LAST) begin
                cnt_d   = '0;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q > ADDR_W'(1)) ? S_INC_LO : S_SETTLE;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            S_SETTLE: begin
              if (cnt_q == SETTLE_LAST) begin
                cnt_d      = '0;
                state_d    = S_ACTIVE;
                cur_addr_d = target_q;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    // Control outputs are registered from the next state so they line up with it.
    ena_d  = (state_d == S_ACTIVE);
    inc_d  = (state_d == S_INC_HI);
    busy_d = (state_d == S_ENA_OFF) || (state_d == S_RESET) || (state_d == S_INC_LO) ||
             (state_d == S_INC_HI) || (state_d == S_SETTLE);
    case (state_d)
      S_IDLE, S_RESET: sel_rst_n_d = 1'b0;
      S_ENA_OFF:       sel_rst_n_d = sel_rst_n_q;
      default:         sel_rst_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      target_q    <= '0;
      cur_addr_q  <= '0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
      short_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      target_q    <= target_d;
      cur_addr_q  <= cur_addr_d;
      sel_rst_n_q <= sel_rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
`ifdef TT_SEL_SEQ_SHORTCUT_EN
      short_q     <= short_d;
`endif
    end
  end

  assign bus.busy           = busy_q;
  assign bus.cur_addr       = cur_addr_q;
  assign bus.ctrl_sel_rst_n = sel_rst_n_q;
  assign bus.ctrl_sel_inc   = inc_q;
  assign bus.ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Scoreboard bench for tt_sel_seq: a ripple-counter model of the controller checks every enable.
module tb_tt_sel_seq;
  localparam int ADDR_W     = 10;
  localparam int RST_CYC    = 2;
  localparam int PULSE_CYC  = 1;
  localparam int SETTLE_CYC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sel_seq_if #(.ADDR_W(ADDR_W)) bus_if ();

  tt_sel_seq #(
    .ADDR_W(ADDR_W), .RST_CYC(RST_CYC), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int addr;
    int cyc;
    int pulses;
    int rstlow;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   seq_pulses = 0;
  int   seq_rstlow = 0;
  int   model_cnt = 0;
  int   viol = 0;
  logic inc_prev = 1'b0;
  logic ena_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model and scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (cyc == acc_cyc) begin
      seq_pulses = 0;
      seq_rstlow = 0;
    end
    if (bus_if.ctrl_sel_inc && !bus_if.ctrl_sel_rst_n) viol++;
    if (!bus_if.ctrl_sel_rst_n) begin
      model_cnt = 0;
      seq_rstlow++;
    end else if (bus_if.ctrl_sel_inc && !inc_prev) begin
      model_cnt++;
      seq_pulses++;
    end
    if (bus_if.ctrl_ena && !ena_prev) begin
      if (sb.size() == 0) begin
        check("spurious_ena", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("txn addr=%0d ena_cyc=%0d pulses=%0d rst_low=%0d cur_addr=%0d model=%0d",
                 e.addr, cyc, seq_pulses, seq_rstlow, bus_if.cur_addr, model_cnt);
        check("ena_latency", cyc, e.cyc);
        check("cur_addr", bus_if.cur_addr, e.addr);
        check("model_cnt", model_cnt, e.addr);
        check("pulse_count", seq_pulses, e.pulses);
        check("rst_low_cycles", seq_rstlow, e.rstlow);
        check("inc_while_rst", viol, 0);
      end
    end
    inc_prev = bus_if.ctrl_sel_inc;
    ena_prev = bus_if.ctrl_ena;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int addr, input int pulses, input int rstlow, input bit full);
    int lat;
    lat = 1 + (full ? RST_CYC : 0) + 2 * PULSE_CYC * pulses + SETTLE_CYC;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = addr[ADDR_W-1:0];
    #1;
    check("req_ready_accept", bus_if.req_ready, 1);
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    acc_cyc = cyc;
    sb.push_back('{addr, acc_cyc + lat, pulses, rstlow});
  endtask

  task automatic send_from_idle(input int addr);
    send(addr, addr, 1 + RST_CYC, 1'b1);
  endtask

  task automatic send_from_active(input int addr, input int cur);
`ifdef TT_SEL_SEQ_SHORTCUT_EN
    if (addr >= cur) send(addr, addr - cur, 0, 1'b0);
    else             send(addr, addr, RST_CYC, 1'b1);
`else
    if (cur < 0) send(addr, addr, 1 + RST_CYC, 1'b1);
    else         send(addr, addr, RST_CYC, 1'b1);
`endif
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
    check("seq_complete", sb.size(), 0);
    check("ena_high", bus_if.ctrl_ena, 1);
  endtask

  task automatic wait_pulses(input int n);
    int i;
    @(negedge clk);
    i = 0;
    while (seq_pulses < n && i < 200) begin
      tick(1);
      i++;
    end
    check("pulses_reached", (seq_pulses >= n), 1);
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_off   = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_sel_rst_n", bus_if.ctrl_sel_rst_n, 0);
    check("rst_inc", bus_if.ctrl_sel_inc, 0);
    check("rst_ena", bus_if.ctrl_ena, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_cur_addr", bus_if.cur_addr, 0);
    check("rst_req_ready", bus_if.req_ready, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", bus_if.req_ready, 1);
    tick(1);

    // Basic select, then addr 0, then back to 3.
    send_from_idle(3);
    wait_done(100);
    send_from_active(0, 3);
    wait_done(100);
    send_from_active(3, 0);
    wait_done(100);

    // req_off in ACTIVE wins over a same-cycle request.
    bus_if.req_off   = 1'b1;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 10'd7;
    #1;
    check("off_ready_low", bus_if.req_ready, 0);
    tick(1);
    bus_if.req_off   = 1'b0;
    bus_if.req_valid = 1'b0;
    #1;
    check("off_ena", bus_if.ctrl_ena, 0);
    check("off_sel_rst_n", bus_if.ctrl_sel_rst_n, 0);
    check("off_busy", bus_if.busy, 0);
    check("off_ready_idle", bus_if.req_ready, 1);
    tick(4);
    check("off_no_accept", bus_if.busy, 0);

    // Reset mid-pulse-train.
    send_from_idle(5);
    wait_pulses(2);
    rst_n = 1'b0;
    tick(1);
    void'(sb.pop_back());
    check("mid_rst_sel_rst_n", bus_if.ctrl_sel_rst_n, 0);
    check("mid_rst_inc", bus_if.ctrl_sel_inc, 0);
    check("mid_rst_ena", bus_if.ctrl_ena, 0);
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_cur_addr", bus_if.cur_addr, 0);
    rst_n = 1'b1;
    tick(1);

    // Abort mid-pulse-train with req_off.
    send_from_idle(5);
    wait_pulses(2);
    bus_if.req_off = 1'b1;
    tick(1);
    bus_if.req_off = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", bus_if.busy, 0);
    check("abort_ena", bus_if.ctrl_ena, 0);
    check("abort_sel_rst_n", bus_if.ctrl_sel_rst_n, 0);
    tick(20);
    check("abort_ena_stays_low", bus_if.ctrl_ena, 0);

    // Upward re-selection (shortcut when enabled), then downward.
    send_from_idle(3);
    wait_done(100);
    send_from_active(5, 3);
    wait_done(100);
    send_from_active(1, 5);
    wait_done(100);

    // Full-range address, with a request ignored while busy.
    send_from_active(1023, 1);
    tick(10);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 10'd9;
    #1;
    check("busy_ready_low", bus_if.req_ready, 0);
    tick(1);
    bus_if.req_valid = 1'b0;
    wait_done(3000);
    check("final_cur_addr", bus_if.cur_addr, 1023);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
